// File: rtl/bin2bcd8_seq.sv
// Sequential 8-bit binary-to-BCD converter (double-dabble, one bit per clock).
// Optional leading-zero blanking is enabled by defining BIN2BCD_LZB_EN.
module bin2bcd8_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  bin,
   output logic        busy,
   output logic        done,
   output logic [11:0] bcd
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t      state;
   logic [7:0]  sr;
   logic [11:0] acc;
   logic [3:0]  cnt;
   logic [11:0] acc_adj;
   logic [11:0] acc_shift;
   logic [11:0] bcd_load;
   logic        unused_msb;

   // Per-digit add-3 correction; 4-bit adds, no carry between digits.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_adj
         always_comb begin
            if (acc[gi*4 +: 4] >= 4'd5)
               acc_adj[gi*4 +: 4] = acc[gi*4 +: 4] + 4'd3;
            else
               acc_adj[gi*4 +: 4] = acc[gi*4 +: 4];
         end
      end
   endgenerate

   // The hundreds digit never exceeds 2, so its top bit is always shifted out as 0.
   assign unused_msb = acc_adj[11];
   assign acc_shift  = {acc_adj[10:0], sr[7]};

   always_comb begin
      bcd_load = acc_shift;
`ifdef BIN2BCD_LZB_EN
      if (acc_shift[11:8] == 4'd0) begin
         bcd_load[11:8] = 4'hF;
         if (acc_shift[7:4] == 4'd0)
            bcd_load[7:4] = 4'hF;
      end
`else
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sr    <= '0;
         acc   <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         bcd   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sr    <= bin;
                  acc   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               acc <= acc_shift;
               sr  <= {sr[6:0], 1'b0};
               cnt <= cnt + 4'd1;
               if (cnt == 4'd7) begin
                  bcd   <= bcd_load;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd8_seq.sv
// Self-checking bench for bin2bcd8_seq: directed scenarios plus randomized
// conversions against a decimal-arithmetic reference (honours BIN2BCD_LZB_EN).
module tb_bin2bcd8_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  bin;
   logic        busy;
   logic        done;
   logic [11:0] bcd;

   int checks;
   int errors;

   bin2bcd8_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: digits from plain decimal arithmetic, then optional blanking.
   function automatic logic [11:0] ref_bcd(input int v);
      logic [3:0] h, t, o;
      h = 4'(v / 100);
      t = 4'((v / 10) % 10);
      o = 4'(v % 10);
`ifdef BIN2BCD_LZB_EN
      if (h == 4'd0) begin
         h = 4'hF;
         if (t == 4'd0) t = 4'hF;
      end
`endif
      return {h, t, o};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps until done is seen or the budget runs out; returns edges consumed (99 on timeout).
   task automatic wait_done(output int n);
      n = 99;
      for (int k = 1; k <= 30; k++) begin
         step();
         if (done) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; bin = 8'd0;
      #12;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b bcd=%h, want 0 0 000", busy, done, bcd);
      end
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         checks++;
         if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
            errors++;
            $display("FAIL idle_no_start: busy=%b done=%b bcd=%h, want 0 0 000", busy, done, bcd);
         end
      end
      $display("reset/idle: bcd=%h busy=%b done=%b", bcd, busy, done);
   endtask

   task automatic test_single();
      int n;
      logic [11:0] prev;
      prev = bcd;
      bin = 8'd225; start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || bcd !== prev) begin
         errors++;
         $display("FAIL single_launch: busy=%b done=%b bcd=%h, want 1 0 %h", busy, done, bcd, prev);
      end
      wait_done(n);
      checks++;
      if (n !== 8 || bcd !== ref_bcd(225) || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_225: latency=%0d bcd=%h busy=%b, want 8 %h 0", n, bcd, busy, ref_bcd(225));
      end
      step();
      checks++;
      if (done !== 1'b0 || bcd !== ref_bcd(225)) begin
         errors++;
         $display("FAIL single_pulse: done=%b bcd=%h, want 0 %h", done, bcd, ref_bcd(225));
      end
      $display("single: bin=225 bcd=%h latency=%0d", bcd, n);
   endtask

   task automatic test_back_to_back();
      int vals[3] = '{81, 0, 100};
      int n;
      bin = 8'(vals[0]); start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         if (i < 2) bin = 8'(vals[i+1]);
         start = 1'b0;
         wait_done(n);
         checks++;
         if (n !== 8 || bcd !== ref_bcd(vals[i])) begin
            errors++;
            $display("FAIL b2b_%0d: latency=%0d bcd=%h, want 8 %h", vals[i], n, bcd, ref_bcd(vals[i]));
         end
         $display("back_to_back: bin=%0d bcd=%h latency=%0d", vals[i], bcd, n);
         if (i < 2) start = 1'b1;
      end
      step();
   endtask

   task automatic test_start_while_busy();
      int n;
      int extra;
      bin = 8'd255; start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      bin = 8'd7; start = 1'b1;
      step();
      start = 1'b0;
      wait_done(n);
      checks++;
      if (n !== 4 || bcd !== ref_bcd(255)) begin
         errors++;
         $display("FAIL busy_start: edges_after_4=%0d bcd=%h, want 4 %h", n, bcd, ref_bcd(255));
      end
      extra = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (done || busy) extra++;
      end
      checks++;
      if (extra !== 0) begin
         errors++;
         $display("FAIL busy_start_ignored: extra_activity_cycles=%0d, want 0", extra);
      end
      $display("start_while_busy: bcd=%h extra=%0d", bcd, extra);
   endtask

   task automatic test_reset_mid();
      int n;
      int seen;
      bin = 8'd144; start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
         errors++;
         $display("FAIL reset_mid_clear: busy=%b done=%b bcd=%h, want 0 0 000", busy, done, bcd);
      end
      step(); step();
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (done || busy) seen++;
      end
      checks++;
      if (seen !== 0 || bcd !== 12'h000) begin
         errors++;
         $display("FAIL reset_mid_nodone: active_cycles=%0d bcd=%h, want 0 000", seen, bcd);
      end
      bin = 8'd49; start = 1'b1;
      step();
      start = 1'b0;
      wait_done(n);
      checks++;
      if (n !== 8 || bcd !== ref_bcd(49)) begin
         errors++;
         $display("FAIL reset_mid_after: latency=%0d bcd=%h, want 8 %h", n, bcd, ref_bcd(49));
      end
      $display("reset_mid: after-reset bin=49 bcd=%h", bcd);
      step();
   endtask

   task automatic test_sweep();
      int n;
      bin = 8'd0; start = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         start = 1'b0;
         bin = 8'($urandom_range(0, 255));
         wait_done(n);
         checks++;
         if (n !== 8 || bcd !== ref_bcd(i * i)) begin
            errors++;
            $display("FAIL sweep_%0d: latency=%0d bcd=%h, want 8 %h", i, n, bcd, ref_bcd(i * i));
         end
         $display("sweep: i=%0d sq=%0d bcd=%h", i, i * i, bcd);
         if (i < 15) begin
            bin = 8'((i + 1) * (i + 1));
            start = 1'b1;
         end
      end
      step();
   endtask

   task automatic test_random();
      int n;
      int v;
      for (int t = 0; t < 30; t++) begin
         v = int'($urandom_range(0, 255));
         bin = 8'(v); start = 1'b1;
         step();
         start = 1'b0;
         n = 99;
         for (int k = 1; k <= 30; k++) begin
            bin = 8'($urandom);
            start = 1'($urandom);
            step();
            if (done) begin
               n = k;
               break;
            end
         end
         start = 1'b0;
         checks++;
         if (n !== 8 || bcd !== ref_bcd(v)) begin
            errors++;
            $display("FAIL random_%0d: latency=%0d bcd=%h, want 8 %h", v, n, bcd, ref_bcd(v));
         end
         $display("random: bin=%0d bcd=%h latency=%0d", v, bcd, n);
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_start_while_busy();
      test_reset_mid();
      test_sweep();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
